// File: rtl/echo_delay.sv
// Audio echo stage: y(n) = sat(x(n) + (x(n-D) >>> GAIN_SHIFT)); define ECHO_FEEDBACK_EN to store y(n) for a recursive echo.
// Latency one sample_clock edge (registered output); no backpressure, one sample is consumed on every edge.
module echo_delay #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int GAIN_SHIFT = 1
) (
  input  logic                     sample_clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        delay_len,
  input  logic signed [DATA_W-1:0] input_sample,
  output logic signed [DATA_W-1:0] output_sample,
  output logic                     echo_active
);

  localparam int MAX_DELAY = 1 << ADDR_W;
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {BYPASS, FILL, RUN} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_ptr;
  logic [ADDR_W-1:0]        fill_cnt;
  logic [ADDR_W-1:0]        fill_cnt_nxt;
  logic [ADDR_W-1:0]        d_lat;
  logic [ADDR_W-1:0]        d_lat_nxt;
  logic signed [DATA_W-1:0] dly_mem [MAX_DELAY];
  logic signed [DATA_W-1:0] rd_dat;
  logic signed [DATA_W-1:0] echo_term;
  logic signed [DATA_W:0]   sum_wide;
  logic signed [DATA_W-1:0] sat_sum;
  logic signed [DATA_W-1:0] y_nxt;
  logic signed [DATA_W-1:0] wr_dat;
  logic                     echo_nxt;

  // Read address is formed from the pre-write pointer, so D>=1 never aliases the slot being written.
  assign rd_ptr    = wr_ptr - d_lat;
  assign rd_dat    = dly_mem[rd_ptr];
  assign echo_term = rd_dat >>> GAIN_SHIFT;
  assign sum_wide  = {input_sample[DATA_W-1], input_sample} + {echo_term[DATA_W-1], echo_term};

  always_comb begin
    sat_sum = sum_wide[DATA_W-1:0];
    if (sum_wide[DATA_W] != sum_wide[DATA_W-1]) begin
      sat_sum = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    state_nxt    = state;
    d_lat_nxt    = d_lat;
    fill_cnt_nxt = fill_cnt;
    y_nxt        = input_sample;
    echo_nxt     = 1'b0;
    if (!enable || delay_len == '0) begin
      state_nxt = BYPASS;
    end else begin
      case (state)
        BYPASS: begin
          state_nxt    = FILL;
          d_lat_nxt    = delay_len;
          fill_cnt_nxt = '0;
        end
        FILL: begin
          if (delay_len != d_lat) begin
            d_lat_nxt    = delay_len;
            fill_cnt_nxt = '0;
          end else begin
            fill_cnt_nxt = fill_cnt + ADDR_W'(1);
            if (fill_cnt == d_lat - ADDR_W'(1)) begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (delay_len != d_lat) begin
            state_nxt    = FILL;
            d_lat_nxt    = delay_len;
            fill_cnt_nxt = '0;
          end else begin
            y_nxt    = sat_sum;
            echo_nxt = 1'b1;
          end
        end
        default: state_nxt = BYPASS;
      endcase
    end
  end

`ifdef ECHO_FEEDBACK_EN
  assign wr_dat = y_nxt;
`else
  assign wr_dat = input_sample;
`endif

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      state         <= BYPASS;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      d_lat         <= '0;
      output_sample <= '0;
      echo_active   <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr + ADDR_W'(1);
      fill_cnt      <= fill_cnt_nxt;
      d_lat         <= d_lat_nxt;
      output_sample <= y_nxt;
      echo_active   <= echo_nxt;
    end
  end

  // Buffer contents survive reset; the fill sequence keeps stale data from reaching the output.
  always_ff @(posedge sample_clock) begin
    if (reset) begin
      dly_mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// Directed + randomized bench for echo_delay against a sample-history reference model.
module tb_echo_delay;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int G      = 1;

  logic                     sample_clock = 1'b0;
  logic                     reset;
  logic                     enable;
  logic [ADDR_W-1:0]        delay_len;
  logic signed [DATA_W-1:0] input_sample;
  logic signed [DATA_W-1:0] output_sample;
  logic                     echo_active;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: every written sample kept by edge index since the start of the run.
  int  hist [0:16383];
  int  m_e      = 0;
  int  m_lat    = 0;
  int  m_d      = 0;
  bit  m_active = 1'b0;
  logic signed [DATA_W-1:0] exp_y;
  logic                     exp_ea;

  echo_delay #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAIN_SHIFT(G)) dut (
    .sample_clock  (sample_clock),
    .reset         (reset),
    .enable        (enable),
    .delay_len     (delay_len),
    .input_sample  (input_sample),
    .output_sample (output_sample),
    .echo_active   (echo_active)
  );

  always #5 sample_clock = ~sample_clock;

  function automatic int floor_div(input int v, input int s);
    int q;
    q = v / s;
    if ((v % s) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check16(input string tag, input logic signed [DATA_W-1:0] got,
                         input logic signed [DATA_W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one sample, advance one edge, update the model, compare outputs.
  task automatic step(input string tag, input logic en, input int d, input logic signed [DATA_W-1:0] x);
    int yv;
    enable       = en;
    delay_len    = ADDR_W'(d);
    input_sample = x;
    @(posedge sample_clock);
    exp_ea = 1'b0;
    yv     = int'(x);
    if (!en || d == 0) begin
      m_active = 1'b0;
    end else if (!m_active || d != m_d) begin
      m_active = 1'b1;
      m_d      = d;
      m_lat    = m_e;
    end else if (m_e - m_lat > m_d) begin
      yv     = clamp(int'(x) + floor_div(hist[m_e - m_d], 2 ** G));
      exp_ea = 1'b1;
    end
    exp_y = DATA_W'(yv);
`ifdef ECHO_FEEDBACK_EN
    hist[m_e] = yv;
`else
    hist[m_e] = int'(x);
`endif
    m_e++;
    #1;
    check16({tag, ".y"}, output_sample, exp_y);
    check1({tag, ".echo_active"}, echo_active, exp_ea);
  endtask

  function automatic logic signed [DATA_W-1:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[DATA_W-1:0];
  endfunction

  initial begin
    logic signed [DATA_W-1:0] xv;
    int                       dv;

    reset        = 1'b1;
    enable       = 1'b0;
    delay_len    = '0;
    input_sample = '0;
    #1 reset = 1'b0;
    #1;
    check16("reset.y", output_sample, 16'sd0);
    check1("reset.echo_active", echo_active, 1'b0);
    repeat (2) @(posedge sample_clock);
    #1;
    check16("reset_hold.y", output_sample, 16'sd0);
    reset = 1'b1;

    // Preload buffer with nonzero data while bypassed.
    for (int i = 0; i < 20; i++) step("bypass", 1'b0, 4, rnd16());

    // Fill suppression: stale buffer data must not leak.
    for (int i = 0; i < 5; i++) begin
      step("fill", 1'b1, 4, 16'sd1000);
      check16("fill.plain", output_sample, 16'sd1000);
    end
    step("fill_run", 1'b1, 4, 16'sd1000);
    check16("fill.first_echo", output_sample, 16'sd1500);
    check1("fill.first_echo_active", echo_active, 1'b1);
    for (int i = 0; i < 4; i++) step("fill_run", 1'b1, 4, 16'sd1000);

    // Impulse response at D=4.
    for (int i = 0; i < 5; i++) step("imp_pre", 1'b1, 4, 16'sd0);
    step("imp", 1'b1, 4, 16'sd16000);
    check16("imp.k", output_sample, 16'sd16000);
    for (int i = 0; i < 3; i++) step("imp_gap", 1'b1, 4, 16'sd0);
    step("imp_echo", 1'b1, 4, 16'sd0);
    check16("imp.k+4", output_sample, 16'sd8000);
    check1("imp.k+4_active", echo_active, 1'b1);
    for (int i = 0; i < 14; i++) step("imp_tail", 1'b1, 4, 16'sd0);

    // Saturation at D=2.
    for (int i = 0; i < 6; i++) step("sat_pos", 1'b1, 2, 16'sd30000);
    check16("sat.pos", output_sample, 16'sd32767);
    for (int i = 0; i < 6; i++) step("sat_neg", 1'b1, 2, -16'sd30000);
    check16("sat.neg", output_sample, -16'sd32768);
    for (int i = 0; i < 4; i++) step("sat_m1", 1'b1, 2, -16'sd1);
    check16("sat.minus_one", output_sample, -16'sd2);

    // Delay change 4 -> 8 in RUN, then enable drop.
    for (int i = 0; i < 12; i++) step("chg_pre", 1'b1, 4, rnd16());
    step("chg_edge", 1'b1, 8, rnd16());
    check1("chg.edge_inactive", echo_active, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("chg_fill", 1'b1, 8, rnd16());
      check1("chg.fill_inactive", echo_active, 1'b0);
    end
    step("chg_run", 1'b1, 8, rnd16());
    check1("chg.run_active", echo_active, 1'b1);
    for (int i = 0; i < 10; i++) step("chg_run", 1'b1, 8, rnd16());
    xv = rnd16();
    step("dis", 1'b0, 8, xv);
    check16("dis.plain", output_sample, xv);

    // Delay change together with enable falling: bypass wins.
    for (int i = 0; i < 8; i++) step("both_pre", 1'b1, 3, rnd16());
    xv = rnd16();
    step("both", 1'b0, 5, xv);
    check16("both.plain", output_sample, xv);
    for (int i = 0; i < 10; i++) step("both_post", 1'b1, 5, rnd16());

    // delay_len 0 with enable high behaves as bypass.
    for (int i = 0; i < 4; i++) step("d0", 1'b1, 0, rnd16());

    // D=1 and the largest legal delay.
    for (int i = 0; i < 12; i++) step("d1", 1'b1, 1, rnd16());
    for (int i = 0; i < 1040; i++) step("dmax", 1'b1, (1 << ADDR_W) - 1, rnd16());

    // Reset mid-RUN.
    for (int i = 0; i < 10; i++) step("rst_pre", 1'b1, 3, rnd16());
    #2 reset = 1'b0;
    #1;
    check16("rst_mid.y", output_sample, 16'sd0);
    check1("rst_mid.echo_active", echo_active, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge sample_clock);
      #1;
      check16("rst_hold.y", output_sample, 16'sd0);
      check1("rst_hold.echo_active", echo_active, 1'b0);
    end
    reset    = 1'b1;
    m_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xv = rnd16();
      step("rst_fill", 1'b1, 3, xv);
      check16("rst_fill.plain", output_sample, xv);
    end
    for (int i = 0; i < 10; i++) step("rst_run", 1'b1, 3, rnd16());

    // Randomized mix of enable, delay and data.
    dv = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) dv = $urandom_range(0, 6);
      step("rand", ($urandom_range(0, 29) != 0), dv, rnd16());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
